// File: rtl/sop_sweep_ctrl.sv
// sop_sweep_ctrl: configurable shared-product SOP evaluator with exhaustive abs_diff error sweep
module sop_sweep_ctrl #(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter int N_PROD = 4,
  parameter int ET = 3,
  localparam int AW = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [2*N_IN-1:0] cfg_lits,
  input  logic [N_OUT-1:0] cfg_act,
  input  logic start,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0] err_count,
  input  logic [N_IN-1:0] probe_in,
  output logic [N_OUT-1:0] probe_out
);
  localparam int H = N_IN / 2;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(2**N_IN - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;
  state_t state;
  logic [N_PROD-1:0][2*N_IN-1:0] lits;
  logic [N_PROD-1:0][N_OUT-1:0] act;
  logic [N_IN:0] vec;
  logic s1_valid;
  logic [N_OUT-1:0] s1_approx, s1_exact, cur_approx, cur_exact, err;
  logic signed [N_OUT:0] d;
  logic [N_OUT:0] mag;
  function automatic logic [N_OUT-1:0] sop(input logic [N_IN-1:0] x,
                                           input logic [N_PROD-1:0][2*N_IN-1:0] l,
                                           input logic [N_PROD-1:0][N_OUT-1:0] a);
    logic [N_OUT-1:0] r;
    logic p;
    r = '0;
    for (int q = 0; q < N_PROD; q++) begin
      p = 1'b1;
      for (int i = 0; i < N_IN; i++)
        p = p & ((l[q][2*i+:2] == 2'b00) || (l[q][2*i+:2] == 2'b01 && x[i]) || (l[q][2*i+:2] == 2'b10 && !x[i]));
      r = r | (a[q] & {N_OUT{p}});
    end
    return r;
  endfunction
  function automatic logic [H-1:0] absd(input logic [H-1:0] x, input logic [H-1:0] y);
    return x > y ? x - y : y - x;
  endfunction
  assign cfg_ready = (state == IDLE || state == DONE) && !start;
  always_comb begin
    cur_approx = sop(vec[N_IN-1:0], lits, act);
    cur_exact = absd(vec[H-1:0], vec[N_IN-1:H]);
    probe_out = sop(probe_in, lits, act);
    d = $signed({1'b0, s1_exact}) - $signed({1'b0, s1_approx});
    mag = d < 0 ? -d : d;
    err = mag[N_OUT] ? '1 : mag[N_OUT-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lits <= '1;
      act <= '0;
      vec <= '0;
      s1_valid <= 1'b0;
      s1_approx <= '0;
      s1_exact <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      max_err <= '0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      s1_valid <= 1'b0;
      if (cfg_valid && cfg_ready && {1'b0, cfg_addr} < (AW+1)'(N_PROD)) begin
        lits[cfg_addr] <= cfg_lits;
        act[cfg_addr] <= cfg_act;
      end
      if (s1_valid) begin
        if (err > max_err) max_err <= err;
        if (err != '0) err_count <= err_count + (N_IN+1)'(1);
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= SWEEP;
          vec <= '0;
          max_err <= '0;
          err_count <= '0;
          busy <= 1'b1;
        end
        SWEEP: begin
          s1_valid <= 1'b1;
          s1_approx <= cur_approx;
          s1_exact <= cur_exact;
          vec <= vec + (N_IN+1)'(1);
          if (vec == LAST) state <= FLUSH;
        end
        FLUSH: if (!s1_valid) begin
          // last vector has been folded into max_err by now
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
          pass <= 32'(max_err) <= 32'(ET);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
